coproc_dispatcher: RTL

Host-side initiator for the matrix coprocessor's instruction port. It buffers 32-bit instruction words written by the host (HPS/bus bridge) in a FIFO. When enabled, it issues them one at a time on instruction/activate_instruction and waits for the coprocessor's completion indication before issuing the next. It also reports progress, a timeout error and queue status back to the host.

---
 rtl/coproc_pkg.sv | 34 +++
 rtl/coproc_dispatcher_instr_fifo.sv | 57 +++++
 rtl/coproc_dispatcher.sv | 133 +++++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor host-side dispatcher:
// instruction opcode values, opcode field position and dispatcher state encoding.
package coproc_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 3;

  localparam logic [3:0] OP_HALT   = 4'd0;
  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_SUM    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_MUL    = 4'd5;
  localparam logic [3:0] OP_TRANSP = 4'd6;
  localparam logic [3:0] OP_OPST   = 4'd7;
  localparam logic [3:0] OP_MULSCL = 4'd8;
  localparam logic [3:0] OP_DET2   = 4'd9;
  localparam logic [3:0] OP_DET3   = 4'd10;
  localparam logic [3:0] OP_DET4   = 4'd11;
  localparam logic [3:0] OP_DET5   = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_ERROR = 3'd4
  } disp_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/coproc_dispatcher_instr_fifo.sv
// Synchronous instruction FIFO with registered full flag and occupancy count.
// The head word is read combinationally so it can be registered on the same pop edge.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [AW:0]      next_level;

  // A push against a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    next_level = level;
    if (push_ok && !pop_ok) next_level = level + 1'b1;
    if (pop_ok && !push_ok) next_level = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= next_level;
      full  <= (next_level == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/coproc_dispatcher.sv
// Host-side instruction dispatcher: queues host words and issues them one at a time
// to the coprocessor, waiting for its done edge with a timeout.
module coproc_dispatcher
  import coproc_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  input  logic                   run,
  input  logic                   clear_err,
  output logic [31:0]            instruction,
  output logic                   activate_instruction,
  input  logic                   done,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   error_timeout,
  output logic [15:0]            issued_count,
  output disp_state_t            dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  disp_state_t state;
  logic [31:0] head;
  logic        empty;
  logic        start;
  logic        done_q;
  logic        done_edge;
  logic        halt_hold;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  instr_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (start),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // halt_hold keeps a HALT from being followed by further issues until run drops.
  assign start     = (state == ST_IDLE) && run && !empty && !error_timeout && !halt_hold;
  assign done_edge = done & ~done_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      instruction          <= '0;
      activate_instruction <= 1'b0;
      busy                 <= 1'b0;
      error_timeout        <= 1'b0;
      issued_count         <= '0;
      tcnt                 <= '0;
      gcnt                 <= '0;
      halt_hold            <= 1'b0;
      done_q               <= 1'b1;
    end else begin
      done_q               <= done;
      activate_instruction <= 1'b0;
      if (!run) halt_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            instruction          <= head;
            activate_instruction <= ~is_halt(head);
            busy                 <= 1'b1;
            state                <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcnt <= '0;
          if (is_halt(instruction)) begin
            halt_hold <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done edge in the expiry cycle still counts as a completion.
          if (done_edge) begin
            issued_count <= issued_count + 16'd1;
            gcnt         <= '0;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_GAP;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            error_timeout <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        ST_ERROR: begin
          if (clear_err) begin
            error_timeout <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
